fpexc_pipe: RTL and testbench
=============================

// Module: fpexc_pipe
// PURPOSE
// Registered, parametrised successor of the combinational FP exception stage. It classifies
// the operands, derives the IEEE flags and the result-manipulation controls, and presents them
// through one valid/ready pipeline stage. It also keeps sticky flags (fflags-style) and a
// saturating invalid-operation counter. It sits between the normaliser/rounder and result packing.
// PARAMETERS
// EXP_W   8   exponent width
// MANT_W  23  fraction width; mantissa ports carry MANT_W+1 bits (hidden bit at MSB)
// CMD_W   4   operation command width; encodings C_FPU01_*_CMD from fpu_defs
// CNT_W   8   width of the invalid-operation event counter
// PORTS
// Clk_CI          in   1         clock
// Rst_RI          in   1         reset, synchronous, active-high
// In_Valid_SI     in   1         input operation valid
// In_Ready_SO     out  1         stage can accept
// Op_SI           in   CMD_W     command
// Sign_a_DI/b     in   1         operand signs (already adjusted for SUB)
// Exp_a_DI/b      in   EXP_W     operand exponents
// Mant_a_DI/b     in   MANT_W+1  operand mantissas
// Mant_norm_DI    in   MANT_W+1  normalised result mantissa
// Mant_rounded_SI in   1         rounding discarded nonzero bits
// Exp_OF_SI       in   1         exponent overflow
// Exp_UF_SI       in   1         exponent underflow
// Cvt_Flags_DI    in   6         F2I flags {OF,UF,Zero,IX,IV,Inf}
// Out_Valid_SO    out  1         output valid
// Out_Ready_SI    in   1         downstream accepts
// Exp_toZero_SO   out  1         force result exponent to zero
// Exp_toInf_SO    out  1         force result exponent to all-ones
// Mant_toZero_SO  out  1         force result fraction to zero
// Flags_DO        out  7         {IV,DZ,OF,UF,IX,Inf,Zero} of the presented result
// Sticky_Clr_SI   in   1         clear the sticky flags
// Sticky_DO       out  5         accumulated {IV,DZ,OF,UF,IX}
// IV_Cnt_DO       out  CNT_W     saturating count of transferred results with IV=1
// BEHAVIOUR
// - Reset: Out_Valid_SO=0; all data outputs, Sticky_DO and IV_Cnt_DO are 0. Reset overrides any in-flight op.
// - In_Ready_SO = ~Out_Valid_SO | Out_Ready_SI. Accept = In_Valid_SI & In_Ready_SO.
// - On accept, results are registered. Latency is 1 cycle: Out_Valid_SO rises the cycle after accept.
// - Outputs hold stable while Out_Valid_SO & ~Out_Ready_SI. Accept together with a transfer gives back-to-back throughput.
// - Classification: Inf = exp all-ones & fraction 0; NaN = exp all-ones & fraction!=0;
//   Zero = exp 0 & mantissa 0 (including the hidden bit). MZ = Mant_norm_DI==0.
// - IV:
//   ADD/SUB = (Inf_a&Inf_b&(Sa^Sb)) | NaN_a | NaN_b
//   MUL     = Inf_a&Zero_b | Inf_b&Zero_a | NaN
//   F2I     = Cvt IV
//   I2F     = 0
// - Inf_t:
//   ADD/SUB = Inf_a^Inf_b | (Inf_a&Inf_b&~(Sa^Sb))
//   MUL     = Inf_a&~Zero_b | Inf_b&~Zero_a
//   Inf     = Inf_t | (Exp_OF&~MZ)
// - OF = (Exp_OF&~MZ) | (~IV&(Inf_a^Inf_b)&Op!=I2F).
//   UF = Exp_UF&Mant_rounded. Zero = MZ&~IV. IX = Mant_rounded|OF. DZ = 0 unless FPEXC_DIV_EN.
// - For F2I, OF/UF/Zero/IX/IV/Inf come straight from Cvt_Flags_DI.
// - Exp_toInf = OF|IV|DZ. Mant_toZero = Inf.
//   Exp_toZero = (Op==I2F) ? Zero_a&~Sa : Exp_UF|(MZ&~Exp_toInf).
// - Unknown command: all flags and controls are 0.
// - Sticky: each transfer (Out_Valid&Out_Ready) ORs {IV,DZ,OF,UF,IX} into Sticky_DO.
//   Sticky_Clr_SI clears first; on a simultaneous transfer the next value is exactly that transfer's flags.
// - IV_Cnt_DO increments on each transfer with IV=1 and saturates at 2^CNT_W-1; it has no wrap.
//   Only Rst_RI clears it.
// CONFIGURATION
// FPEXC_DIV_EN defined: decodes C_FPU01_DIV_CMD and C_FPU01_SQRT_CMD.
//   DIV: IV = NaN | (Inf_a&Inf_b) | (Zero_a&Zero_b); DZ = Zero_b&~Zero_a&~Inf_a&~NaN_a; Inf_t = DZ | (Inf_a&~Inf_b&~NaN_b).
//   SQRT: IV = NaN_a | (Sa&~Zero_a); Inf_t = Inf_a&~Sa.
// FPEXC_DIV_EN undefined: DIV/SQRT are unknown commands, all flags 0, DZ tied 0, and no divider logic is synthesised.
// TESTING
// (EXP_W=8, MANT_W=23)
// 1. ADD a=+Inf(FF,800000) b=-Inf(FF,800000 Sb=1) -> next cycle Out_Valid=1, Flags=7'b1000000, Exp_toInf=1, Mant_toZero=0, Sticky=5'b10000, IV_Cnt=1.
// 2. MUL a=Inf b=+0(00,000000) -> IV=1, Inf=0. MUL a=Inf b=1.0(7F,800000) -> Inf=1, OF=1, IX=1, Mant_toZero=1.
// 3. Hold Out_Ready=0, issue 2 ops -> In_Ready=0 after the first; outputs frozen 5 cycles; Out_Ready=1 -> op1 then op2 on consecutive cycles.
// 4. Sticky=5'b10000, then Sticky_Clr_SI=1 in the same cycle as a transfer with IX=1 -> Sticky=5'b00001.
// 5. FPEXC_DIV_EN: DIV 1.0/+0 -> DZ=1, Inf=1, Exp_toInf=1, IV=0. Without the macro -> Flags=0, Exp_toInf=0.
// 6. CNT_W=2: 5 transferred invalid ops -> IV_Cnt_DO=3 (held). Assert Rst_RI mid-stall -> Out_Valid=0, Sticky=0, IV_Cnt=0 next cycle.

Source files
------------

// File: rtl/fpexc_pipe.sv
// Registered FP exception stage: operand classification, IEEE flags, result controls, sticky flags, IV counter.
// Define FPEXC_DIV_EN to decode the DIV and SQRT commands (otherwise they fall to the unknown-command path).
module fpexc_pipe #(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned MANT_W = 23,
  parameter int unsigned CMD_W  = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              Clk_CI,
  input  logic              Rst_RI,
  input  logic              In_Valid_SI,
  output logic              In_Ready_SO,
  input  logic [CMD_W-1:0]  Op_SI,
  input  logic              Sign_a_DI,
  input  logic              Sign_b_DI,
  input  logic [EXP_W-1:0]  Exp_a_DI,
  input  logic [EXP_W-1:0]  Exp_b_DI,
  input  logic [MANT_W:0]   Mant_a_DI,
  input  logic [MANT_W:0]   Mant_b_DI,
  input  logic [MANT_W:0]   Mant_norm_DI,
  input  logic              Mant_rounded_SI,
  input  logic              Exp_OF_SI,
  input  logic              Exp_UF_SI,
  input  logic [5:0]        Cvt_Flags_DI,
  output logic              Out_Valid_SO,
  input  logic              Out_Ready_SI,
  output logic              Exp_toZero_SO,
  output logic              Exp_toInf_SO,
  output logic              Mant_toZero_SO,
  output logic [6:0]        Flags_DO,
  input  logic              Sticky_Clr_SI,
  output logic [4:0]        Sticky_DO,
  output logic [CNT_W-1:0]  IV_Cnt_DO
);

  // Command encodings mirror C_FPU01_*_CMD in fpu_defs.
  localparam logic [CMD_W-1:0] C_FPU01_ADD_CMD  = CMD_W'(4'd0);
  localparam logic [CMD_W-1:0] C_FPU01_SUB_CMD  = CMD_W'(4'd1);
  localparam logic [CMD_W-1:0] C_FPU01_MUL_CMD  = CMD_W'(4'd2);
  localparam logic [CMD_W-1:0] C_FPU01_I2F_CMD  = CMD_W'(4'd4);
  localparam logic [CMD_W-1:0] C_FPU01_F2I_CMD  = CMD_W'(4'd5);
`ifdef FPEXC_DIV_EN
  localparam logic [CMD_W-1:0] C_FPU01_DIV_CMD  = CMD_W'(4'd3);
  localparam logic [CMD_W-1:0] C_FPU01_SQRT_CMD = CMD_W'(4'd6);
`endif

  logic inf_a_s, inf_b_s, nan_a_s, nan_b_s, zero_a_s, zero_b_s, mz_s;
  logic known_s, f2i_s, i2f_s, iv_op_s, dz_op_s, inf_t_s;
  logic iv_s, dz_s, of_s, uf_s, ix_s, inf_s, zero_s;
  logic to_zero_s, to_inf_s, mant_zero_s;
  logic [9:0] res_s;

  logic             out_valid_q, out_valid_d;
  logic [9:0]       res_q, res_d;
  logic [4:0]       sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept_s, xfer_s;
  logic [4:0]       xfer_flags_s;

  assign inf_a_s  = (&Exp_a_DI) & ~(|Mant_a_DI[MANT_W-1:0]);
  assign inf_b_s  = (&Exp_b_DI) & ~(|Mant_b_DI[MANT_W-1:0]);
  assign nan_a_s  = (&Exp_a_DI) &  (|Mant_a_DI[MANT_W-1:0]);
  assign nan_b_s  = (&Exp_b_DI) &  (|Mant_b_DI[MANT_W-1:0]);
  assign zero_a_s = ~(|Exp_a_DI) & ~(|Mant_a_DI);
  assign zero_b_s = ~(|Exp_b_DI) & ~(|Mant_b_DI);
  assign mz_s     = ~(|Mant_norm_DI);

  // Per-command invalid / infinity / divide-by-zero terms.
  always_comb begin
    known_s = 1'b1;
    f2i_s   = 1'b0;
    i2f_s   = 1'b0;
    iv_op_s = 1'b0;
    dz_op_s = 1'b0;
    inf_t_s = 1'b0;
    case (Op_SI)
      C_FPU01_ADD_CMD, C_FPU01_SUB_CMD: begin
        iv_op_s = (inf_a_s & inf_b_s & (Sign_a_DI ^ Sign_b_DI)) | nan_a_s | nan_b_s;
        inf_t_s = (inf_a_s ^ inf_b_s) | (inf_a_s & inf_b_s & ~(Sign_a_DI ^ Sign_b_DI));
      end
      C_FPU01_MUL_CMD: begin
        iv_op_s = (inf_a_s & zero_b_s) | (inf_b_s & zero_a_s) | nan_a_s | nan_b_s;
        inf_t_s = (inf_a_s & ~zero_b_s) | (inf_b_s & ~zero_a_s);
      end
      C_FPU01_I2F_CMD: i2f_s = 1'b1;
      C_FPU01_F2I_CMD: f2i_s = 1'b1;
`ifdef FPEXC_DIV_EN
      C_FPU01_DIV_CMD: begin
        iv_op_s = nan_a_s | nan_b_s | (inf_a_s & inf_b_s) | (zero_a_s & zero_b_s);
        dz_op_s = zero_b_s & ~zero_a_s & ~inf_a_s & ~nan_a_s;
        inf_t_s = (zero_b_s & ~zero_a_s & ~inf_a_s & ~nan_a_s) | (inf_a_s & ~inf_b_s & ~nan_b_s);
      end
      C_FPU01_SQRT_CMD: begin
        iv_op_s = nan_a_s | (Sign_a_DI & ~zero_a_s);
        inf_t_s = inf_a_s & ~Sign_a_DI;
      end
`endif
      default: known_s = 1'b0;
    endcase
  end

  // Flag word and result-manipulation controls for the incoming op.
  always_comb begin
    iv_s = 1'b0; dz_s = 1'b0; of_s = 1'b0; uf_s = 1'b0;
    ix_s = 1'b0; inf_s = 1'b0; zero_s = 1'b0;
    to_zero_s = 1'b0; to_inf_s = 1'b0; mant_zero_s = 1'b0;
    if (!known_s) begin
      iv_s = 1'b0;
    end else if (f2i_s) begin
      {of_s, uf_s, zero_s, ix_s, iv_s, inf_s} = Cvt_Flags_DI;
    end else begin
      iv_s   = iv_op_s;
      dz_s   = dz_op_s;
      of_s   = (Exp_OF_SI & ~mz_s) | (~iv_op_s & (inf_a_s ^ inf_b_s) & ~i2f_s);
      uf_s   = Exp_UF_SI & Mant_rounded_SI;
      zero_s = mz_s & ~iv_op_s;
      ix_s   = Mant_rounded_SI | of_s;
      inf_s  = inf_t_s | (Exp_OF_SI & ~mz_s);
    end
    if (known_s) begin
      to_inf_s    = of_s | iv_s | dz_s;
      mant_zero_s = inf_s;
      to_zero_s   = i2f_s ? (zero_a_s & ~Sign_a_DI) : (Exp_UF_SI | (mz_s & ~to_inf_s));
    end else begin
      to_inf_s = 1'b0;
    end
  end

  assign res_s = {to_zero_s, to_inf_s, mant_zero_s, iv_s, dz_s, of_s, uf_s, ix_s, inf_s, zero_s};

  assign In_Ready_SO  = ~out_valid_q | Out_Ready_SI;
  assign accept_s     = In_Valid_SI & In_Ready_SO;
  assign xfer_s       = out_valid_q & Out_Ready_SI;
  assign xfer_flags_s = xfer_s ? res_q[6:2] : 5'b00000;

  // Next state of the pipeline register, sticky flags and IV counter.
  always_comb begin
    out_valid_d = accept_s | (out_valid_q & ~Out_Ready_SI);
    res_d       = accept_s ? res_s : res_q;
    if (Sticky_Clr_SI) begin
      sticky_d = xfer_flags_s;
    end else begin
      sticky_d = sticky_q | xfer_flags_s;
    end
    if (xfer_s && res_q[6] && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      out_valid_q <= 1'b0;
      res_q       <= 10'd0;
      sticky_q    <= 5'd0;
      cnt_q       <= {CNT_W{1'b0}};
    end else begin
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      sticky_q    <= sticky_d;
      cnt_q       <= cnt_d;
    end
  end

  assign Out_Valid_SO   = out_valid_q;
  assign Exp_toZero_SO  = res_q[9];
  assign Exp_toInf_SO   = res_q[8];
  assign Mant_toZero_SO = res_q[7];
  assign Flags_DO       = res_q[6:0];
  assign Sticky_DO      = sticky_q;
  assign IV_Cnt_DO      = cnt_q;

endmodule

// File: tb/tb_fpexc_pipe.sv
// Bench for fpexc_pipe: directed literal cases plus random traffic checked against a behavioural model.
module tb_fpexc_pipe;
  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, MUL = 4'd2, DIV = 4'd3, I2F = 4'd4, F2I = 4'd5, SQRT = 4'd6;

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, sticky_clr = 1'b0;
  logic [3:0] op = 4'd0;
  logic sa = 1'b0, sb = 1'b0, rnd = 1'b0, eof = 1'b0, euf = 1'b0;
  logic [7:0] ea = 8'd0, eb = 8'd0;
  logic [23:0] ma = 24'd0, mb = 24'd0, mn = 24'd0;
  logic [5:0] cvt = 6'd0;
  logic to_zero, to_inf, mant_zero;
  logic [6:0] flags;
  logic [4:0] sticky;
  logic [CNT_W-1:0] iv_cnt;

  int n_chk = 0, n_fail = 0;
  logic m_started = 1'b0, m_valid = 1'b0;
  logic [9:0] m_res = 10'd0;
  logic [4:0] m_sticky = 5'd0;
  int m_cnt = 0;

  fpexc_pipe #(.EXP_W(8), .MANT_W(23), .CMD_W(4), .CNT_W(CNT_W)) dut (
    .Clk_CI(clk), .Rst_RI(rst), .In_Valid_SI(in_valid), .In_Ready_SO(in_ready), .Op_SI(op),
    .Sign_a_DI(sa), .Sign_b_DI(sb), .Exp_a_DI(ea), .Exp_b_DI(eb), .Mant_a_DI(ma), .Mant_b_DI(mb),
    .Mant_norm_DI(mn), .Mant_rounded_SI(rnd), .Exp_OF_SI(eof), .Exp_UF_SI(euf), .Cvt_Flags_DI(cvt),
    .Out_Valid_SO(out_valid), .Out_Ready_SI(out_ready), .Exp_toZero_SO(to_zero), .Exp_toInf_SO(to_inf),
    .Mant_toZero_SO(mant_zero), .Flags_DO(flags), .Sticky_Clr_SI(sticky_clr), .Sticky_DO(sticky),
    .IV_Cnt_DO(iv_cnt));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: result word {toZero,toInf,mantZero,IV,DZ,OF,UF,IX,Inf,Zero} from IEEE classification.
  function automatic logic [9:0] ref_model(input logic [3:0] o, input logic s_a, input logic s_b,
      input logic [7:0] e_a, input logic [7:0] e_b, input logic [23:0] m_a, input logic [23:0] m_b,
      input logic [23:0] m_n, input logic r, input logic ovf, input logic unf, input logic [5:0] c);
    bit a_inf, b_inf, a_nan, b_nan, a_zero, b_zero, res_zero, known, inv, dz, inf_t;
    bit f_of, f_uf, f_zero, f_ix, f_iv, f_inf, t_inf, t_zero;
    a_inf = (e_a == 8'hFF) && (m_a[22:0] == 23'd0);
    b_inf = (e_b == 8'hFF) && (m_b[22:0] == 23'd0);
    a_nan = (e_a == 8'hFF) && !a_inf;
    b_nan = (e_b == 8'hFF) && !b_inf;
    a_zero = (e_a == 8'd0) && (m_a == 24'd0);
    b_zero = (e_b == 8'd0) && (m_b == 24'd0);
    res_zero = (m_n == 24'd0);
    known = 1; inv = 0; dz = 0; inf_t = 0;
    if (o == ADD || o == SUB) begin
      inv = (a_inf && b_inf && s_a != s_b) || a_nan || b_nan;
      inf_t = (a_inf != b_inf) || (a_inf && b_inf && s_a == s_b);
    end else if (o == MUL) begin
      inv = (a_inf && b_zero) || (b_inf && a_zero) || a_nan || b_nan;
      inf_t = (a_inf && !b_zero) || (b_inf && !a_zero);
    end else if (o == I2F || o == F2I) begin
      inv = 0;
`ifdef FPEXC_DIV_EN
    end else if (o == DIV) begin
      inv = a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero);
      dz = b_zero && !a_zero && !a_inf && !a_nan;
      inf_t = dz || (a_inf && !b_inf && !b_nan);
    end else if (o == SQRT) begin
      inv = a_nan || (s_a && !a_zero);
      inf_t = a_inf && !s_a;
`endif
    end else begin
      known = 0;
    end
    if (!known) return 10'd0;
    if (o == F2I) begin
      {f_of, f_uf, f_zero, f_ix, f_iv, f_inf} = c;
      dz = 0;
    end else begin
      f_iv = inv;
      f_of = (ovf && !res_zero) || (!inv && (a_inf != b_inf) && o != I2F);
      f_uf = unf && r;
      f_zero = res_zero && !inv;
      f_ix = r || f_of;
      f_inf = inf_t || (ovf && !res_zero);
    end
    t_inf = f_of || f_iv || dz;
    t_zero = (o == I2F) ? (a_zero && !s_a) : (unf || (res_zero && !t_inf));
    return {t_zero, t_inf, f_inf, f_iv, dz, f_of, f_uf, f_ix, f_inf, f_zero};
  endfunction

  // Model of the handshake, sticky flags and saturating counter.
  always @(posedge clk) begin
    m_started <= 1'b1;
    if (rst) begin
      m_valid <= 1'b0; m_res <= 10'd0; m_sticky <= 5'd0; m_cnt <= 0;
    end else begin
      if (in_valid && (!m_valid || out_ready)) begin
        m_valid <= 1'b1;
        m_res <= ref_model(op, sa, sb, ea, eb, ma, mb, mn, rnd, eof, euf, cvt);
      end else if (out_ready) begin
        m_valid <= 1'b0;
      end
      if (sticky_clr) m_sticky <= (m_valid && out_ready) ? m_res[6:2] : 5'd0;
      else if (m_valid && out_ready) m_sticky <= m_sticky | m_res[6:2];
      if (m_valid && out_ready && m_res[6] && m_cnt < CNT_MAX) m_cnt <= m_cnt + 1;
    end
  end

  // Compare DUT against the model every cycle.
  always @(negedge clk) begin
    if (m_started) begin
      chk("valid", 32'(out_valid), 32'(m_valid));
      chk("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
      chk("result", 32'({to_zero, to_inf, mant_zero, flags}), 32'(m_res));
      chk("sticky", 32'(sticky), 32'(m_sticky));
      chk("iv_cnt", 32'(iv_cnt), 32'(m_cnt));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] o, input logic s_a, input logic [7:0] e_a, input logic [23:0] m_a,
                        input logic s_b, input logic [7:0] e_b, input logic [23:0] m_b, input logic r);
    op = o; sa = s_a; ea = e_a; ma = m_a; sb = s_b; eb = e_b; mb = m_b; rnd = r;
    mn = 24'h800000; eof = 1'b0; euf = 1'b0; cvt = 6'd0; in_valid = 1'b1;
  endtask

  task automatic rand_operand(output logic s, output logic [7:0] e, output logic [23:0] m);
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 4))
      0: begin e = 8'h00; m = 24'h000000; end
      1: begin e = 8'hFF; m = 24'h800000; end
      2: begin e = 8'hFF; m = {1'b1, 23'($urandom) | 23'd1}; end
      3: begin e = 8'($urandom_range(1, 254)); m = {1'b1, 23'($urandom)}; end
      default: begin e = 8'($urandom); m = 24'($urandom); end
    endcase
  endtask

  initial begin
    repeat (2) cyc();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_flags", 32'({to_zero, to_inf, mant_zero, flags}), 32'd0);
    chk("rst_sticky_cnt", 32'({sticky, iv_cnt}), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;

    // +Inf + -Inf
    set_op(ADD, 1'b0, 8'hFF, 24'h800000, 1'b1, 8'hFF, 24'h800000, 1'b0);
    cyc(); in_valid = 1'b0;
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_flags", 32'(flags), 32'b1000000);
    chk("t1_ctrl", 32'({to_inf, mant_zero}), 32'b10);
    cyc();
    chk("t1_sticky", 32'(sticky), 32'b10000);
    chk("t1_cnt", 32'(iv_cnt), 32'd1);

    // Inf * 0 and Inf * 1.0
    set_op(MUL, 1'b0, 8'hFF, 24'h800000, 1'b0, 8'h00, 24'h000000, 1'b0);
    cyc(); in_valid = 1'b0;
    chk("t2_inf_x_zero", 32'({to_zero, to_inf, mant_zero, flags}), 32'b010_1000000);
    set_op(MUL, 1'b0, 8'hFF, 24'h800000, 1'b0, 8'h7F, 24'h800000, 1'b0);
    cyc(); in_valid = 1'b0;
    chk("t2_inf_x_one", 32'({to_zero, to_inf, mant_zero, flags}), 32'b011_0010110);
    cyc();

    // Stall with two ops queued
    out_ready = 1'b0;
    set_op(MUL, 1'b0, 8'hFF, 24'h800000, 1'b0, 8'h7F, 24'h800000, 1'b0);
    cyc();
    chk("t3_ready_low", 32'(in_ready), 32'd0);
    set_op(ADD, 1'b0, 8'hFF, 24'h800000, 1'b1, 8'hFF, 24'h800000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t3_hold", 32'({out_valid, flags}), 32'b1_0010110);
    end
    out_ready = 1'b1; #1;
    chk("t3_ready_high", 32'(in_ready), 32'd1);
    cyc(); in_valid = 1'b0;
    chk("t3_second", 32'({out_valid, flags}), 32'b1_1000000);
    cyc();
    chk("t3_drained", 32'(out_valid), 32'd0);

    // Sticky clear coinciding with a transfer
    sticky_clr = 1'b1; cyc(); sticky_clr = 1'b0;
    chk("t4_clr", 32'(sticky), 32'd0);
    set_op(ADD, 1'b0, 8'hFF, 24'h800000, 1'b1, 8'hFF, 24'h800000, 1'b0);
    cyc(); in_valid = 1'b0; cyc();
    chk("t4_iv", 32'(sticky), 32'b10000);
    set_op(ADD, 1'b0, 8'h7F, 24'h800000, 1'b0, 8'h7F, 24'h800000, 1'b1);
    cyc(); in_valid = 1'b0;
    chk("t4_ix_flags", 32'(flags), 32'b0000100);
    sticky_clr = 1'b1; cyc(); sticky_clr = 1'b0;
    chk("t4_clr_xfer", 32'(sticky), 32'b00001);

    // 1.0 / +0
    set_op(DIV, 1'b0, 8'h7F, 24'h800000, 1'b0, 8'h00, 24'h000000, 1'b0);
    cyc(); in_valid = 1'b0;
`ifdef FPEXC_DIV_EN
    chk("t5_div", 32'({to_zero, to_inf, mant_zero, flags}), 32'b011_0100010);
`else
    chk("t5_div", 32'({to_zero, to_inf, mant_zero, flags}), 32'd0);
`endif
    cyc();

    // Counter saturation
    set_op(ADD, 1'b0, 8'hFF, 24'h800000, 1'b1, 8'hFF, 24'h800000, 1'b0);
    repeat (CNT_MAX + 5) cyc();
    in_valid = 1'b0; cyc();
    chk("cnt_sat", 32'(iv_cnt), 32'(CNT_MAX));

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      sticky_clr = ($urandom_range(0, 19) == 0);
      op = 4'($urandom_range(0, 15));
      rand_operand(sa, ea, ma);
      rand_operand(sb, eb, mb);
      mn = ($urandom_range(0, 3) == 0) ? 24'd0 : 24'($urandom);
      rnd = 1'($urandom); eof = 1'($urandom); euf = 1'($urandom); cvt = 6'($urandom);
      cyc();
    end
    sticky_clr = 1'b0;

    // Reset during a stall
    out_ready = 1'b0;
    set_op(ADD, 1'b0, 8'hFF, 24'h800000, 1'b1, 8'hFF, 24'h800000, 1'b0);
    cyc(); in_valid = 1'b0; cyc();
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_state", 32'({sticky, iv_cnt, flags}), 32'd0);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
